// File: rtl/reg_bank_param.sv
// Bank of NUM_REGS registers sharing one function select and data input,
// with per-register sticky wrap flags and two combinational read ports.
module reg_bank_param #(
    parameter int WIDTH    = 32,
    parameter int NUM_REGS = 4,
    parameter int SELW     = $clog2(NUM_REGS)
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic [NUM_REGS-1:0] e_i,
    input  logic [2:0]          fun_sel_i,
    input  logic [WIDTH-1:0]    i_i,
    input  logic [SELW-1:0]     out_a_sel_i,
    input  logic [SELW-1:0]     out_b_sel_i,
    output logic [WIDTH-1:0]    out_a_o,
    output logic [WIDTH-1:0]    out_b_o,
    output logic [NUM_REGS-1:0] wrap_o
);

    typedef enum logic [2:0] {
        FS_DEC   = 3'b000,
        FS_INC   = 3'b001,
        FS_LOAD  = 3'b010,
        FS_CLR   = 3'b011,
        FS_LD8   = 3'b100,
        FS_LD16  = 3'b101,
        FS_SHL8  = 3'b110,
        FS_SEXT  = 3'b111
    } fun_sel_e;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic [WIDTH-1:0] zext8;
    logic [WIDTH-1:0] zext16;
    logic [WIDTH-1:0] sext16;
    logic [WIDTH-1:0] rd_arr [NUM_REGS];

    // Load variants derived from I are the same for every register.
    assign zext8  = WIDTH'(i_i[7:0]);
    assign zext16 = WIDTH'(i_i[15:0]);
    assign sext16 = WIDTH'($signed(i_i[15:0]));

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            logic [WIDTH-1:0] val_q;
            logic [WIDTH-1:0] val_d;
            logic             wrap_q;
            logic             wrap_d;

            always_comb begin
                val_d  = val_q;
                wrap_d = wrap_q;
                if (e_i[gi]) begin
                    case (fun_sel_e'(fun_sel_i))
                        FS_DEC: begin
                            val_d = val_q - ONE;
                            if (val_q == '0) wrap_d = 1'b1;
                        end
                        FS_INC: begin
                            val_d = val_q + ONE;
                            if (val_q == ALL_ONES) wrap_d = 1'b1;
                        end
                        FS_LOAD: val_d = i_i;
                        FS_CLR: begin
                            val_d  = '0;
                            wrap_d = 1'b0;
                        end
                        FS_LD8:  val_d = zext8;
                        FS_LD16: val_d = zext16;
                        FS_SHL8: val_d = {val_q[WIDTH-9:0], i_i[7:0]};
                        FS_SEXT: val_d = sext16;
                        default: val_d = val_q;
                    endcase
                end
            end

            always_ff @(posedge clock_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    val_q  <= '0;
                    wrap_q <= 1'b0;
                end else begin
                    val_q  <= val_d;
                    wrap_q <= wrap_d;
                end
            end

            assign rd_arr[gi] = val_q;
            assign wrap_o[gi] = wrap_q;
        end
    endgenerate

    // Reads see pre-edge state only; there is deliberately no write bypass.
    assign out_a_o = rd_arr[out_a_sel_i];
    assign out_b_o = rd_arr[out_b_sel_i];

endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: directed scenarios at 32x4 and 16x8
// plus randomized traffic checked against an arithmetic reference model.
module tb_reg_bank_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic [3:0]  a_e;
    logic [2:0]  a_fs;
    logic [31:0] a_i;
    logic [1:0]  a_sa, a_sb;
    logic [31:0] a_oa, a_ob;
    logic [3:0]  a_wrap;

    logic [7:0]  b_e;
    logic [2:0]  b_fs;
    logic [15:0] b_i;
    logic [2:0]  b_sa, b_sb;
    logic [15:0] b_oa, b_ob;
    logic [7:0]  b_wrap;

    longint unsigned ma [4];
    logic [3:0]      mwa;
    longint unsigned mb [8];
    logic [7:0]      mwb;

    int tests = 0;
    int fails = 0;

    reg_bank_param #(.WIDTH(32), .NUM_REGS(4)) dut_a (
        .clock_i(clk), .reset_ni(rst_n), .e_i(a_e), .fun_sel_i(a_fs), .i_i(a_i),
        .out_a_sel_i(a_sa), .out_b_sel_i(a_sb), .out_a_o(a_oa), .out_b_o(a_ob),
        .wrap_o(a_wrap)
    );

    reg_bank_param #(.WIDTH(16), .NUM_REGS(8)) dut_b (
        .clock_i(clk), .reset_ni(rst_n), .e_i(b_e), .fun_sel_i(b_fs), .i_i(b_i),
        .out_a_sel_i(b_sa), .out_b_sel_i(b_sb), .out_a_o(b_oa), .out_b_o(b_ob),
        .wrap_o(b_wrap)
    );

    // Reference: plain modular arithmetic on a w-bit value.
    function automatic void model_op(input logic [2:0] fs, input longint unsigned q,
                                     input longint unsigned din, input int w,
                                     output longint unsigned nq, output bit set_w,
                                     output bit clr_w);
        longint unsigned mask;
        mask  = (64'd1 << w) - 64'd1;
        set_w = 1'b0;
        clr_w = 1'b0;
        case (fs)
            3'd0: begin nq = (q + mask) & mask; set_w = (q == 0); end
            3'd1: begin nq = (q + 1) & mask;    set_w = (q == mask); end
            3'd2: nq = din & mask;
            3'd3: begin nq = 0; clr_w = 1'b1; end
            3'd4: nq = din & 64'hFF;
            3'd5: nq = din & 64'hFFFF;
            3'd6: nq = ((q * 256) + (din & 64'hFF)) & mask;
            default: nq = ((din >> 15) & 1) ? ((din & 64'hFFFF) | (mask & ~64'hFFFF))
                                             : (din & 64'hFFFF);
        endcase
    endfunction

    task automatic write_a(input logic [3:0] e, input logic [2:0] fs, input logic [31:0] d);
        longint unsigned nq;
        bit sw, cw;
        a_e = e; a_fs = fs; a_i = d;
        for (int k = 0; k < 4; k++) begin
            if (e[k]) begin
                model_op(fs, ma[k], {32'd0, d}, 32, nq, sw, cw);
                ma[k] = nq;
                if (sw) mwa[k] = 1'b1;
                if (cw) mwa[k] = 1'b0;
            end
        end
        @(posedge clk); #1;
        a_e = '0;
    endtask

    task automatic write_b(input logic [7:0] e, input logic [2:0] fs, input logic [15:0] d);
        longint unsigned nq;
        bit sw, cw;
        b_e = e; b_fs = fs; b_i = d;
        for (int k = 0; k < 8; k++) begin
            if (e[k]) begin
                model_op(fs, mb[k], {48'd0, d}, 16, nq, sw, cw);
                mb[k] = nq;
                if (sw) mwb[k] = 1'b1;
                if (cw) mwb[k] = 1'b0;
            end
        end
        @(posedge clk); #1;
        b_e = '0;
    endtask

    task automatic clear_models();
        for (int k = 0; k < 4; k++) ma[k] = 0;
        for (int k = 0; k < 8; k++) mb[k] = 0;
        mwa = '0;
        mwb = '0;
    endtask

    task automatic test_reset();
        write_a(4'b0100, 3'b010, 32'h1234);
        write_a(4'b1000, 3'b011, 32'h0);
        write_a(4'b1000, 3'b000, 32'h0);
        a_sa = 2'd2; a_sb = 2'd3; #1;
        tests++;
        if (a_oa !== 32'h1234) begin
            fails++; $display("FAIL reset_preload R2: got %h want %h", a_oa, 32'h1234);
        end
        tests++;
        if (a_wrap !== 4'b1000) begin
            fails++; $display("FAIL reset_prewrap: got %b want %b", a_wrap, 4'b1000);
        end
        rst_n = 1'b0; #1;
        tests++;
        if (a_oa !== 32'h0 || a_ob !== 32'h0) begin
            fails++; $display("FAIL reset_async outA/outB: got %h/%h want 0/0", a_oa, a_ob);
        end
        tests++;
        if (a_wrap !== 4'b0 || b_wrap !== 8'b0) begin
            fails++; $display("FAIL reset_async wrap: got %b/%b want 0/0", a_wrap, b_wrap);
        end
        a_e = 4'hF; a_fs = 3'b010; a_i = 32'hDEADBEEF;
        @(posedge clk); #1;
        for (int k = 0; k < 4; k++) begin
            a_sa = 2'(k); #1;
            tests++;
            if (a_oa !== 32'h0) begin
                fails++; $display("FAIL reset_wins R%0d: got %h want 0", k, a_oa);
            end
        end
        a_e = '0;
        rst_n = 1'b1;
        clear_models();
        #2;
        write_a(4'b0001, 3'b010, 32'h55);
        a_sa = 2'd0; #1;
        tests++;
        if (a_oa !== 32'h55) begin
            fails++; $display("FAIL reset_first_write R0: got %h want %h", a_oa, 32'h55);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_multi_inc();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h00010000; exp_v[1] = 32'h11;
        exp_v[2] = 32'hAAAA5555; exp_v[3] = 32'h12345678;
        write_a(4'b0001, 3'b010, 32'h0000FFFF);
        write_a(4'b0010, 3'b010, 32'h10);
        write_a(4'b0100, 3'b010, 32'hAAAA5555);
        write_a(4'b1000, 3'b010, 32'h12345678);
        write_a(4'b0011, 3'b001, 32'hFFFFFFFF);
        for (int k = 0; k < 4; k++) begin
            a_sa = 2'(k); a_sb = 2'(3 - k); #1;
            tests++;
            if (a_oa !== exp_v[k] || a_ob !== exp_v[3-k]) begin
                fails++;
                $display("FAIL multi_inc R%0d/R%0d: got %h/%h want %h/%h",
                         k, 3 - k, a_oa, a_ob, exp_v[k], exp_v[3-k]);
            end
        end
        $display("[TB] test_multi_inc done");
    endtask

    task automatic test_wrap();
        a_sa = 2'd3;
        write_a(4'b1000, 3'b010, 32'hFFFFFFFF);
        write_a(4'b1000, 3'b001, 32'h0);
        tests++;
        if (a_oa !== 32'h0 || a_wrap[3] !== 1'b1) begin
            fails++; $display("FAIL wrap_inc: got %h w=%b want 0 w=1", a_oa, a_wrap[3]);
        end
        repeat (3) write_a(4'b1000, 3'b001, 32'h0);
        tests++;
        if (a_oa !== 32'h3 || a_wrap[3] !== 1'b1) begin
            fails++; $display("FAIL wrap_sticky: got %h w=%b want 3 w=1", a_oa, a_wrap[3]);
        end
        write_a(4'b1000, 3'b011, 32'h0);
        tests++;
        if (a_oa !== 32'h0 || a_wrap !== 4'b0000) begin
            fails++; $display("FAIL wrap_clear: got %h w=%b want 0 w=0000", a_oa, a_wrap);
        end
        write_a(4'b1000, 3'b000, 32'h0);
        tests++;
        if (a_oa !== 32'hFFFFFFFF || a_wrap !== 4'b1000) begin
            fails++; $display("FAIL wrap_dec: got %h w=%b want ffffffff w=1000", a_oa, a_wrap);
        end
        $display("[TB] test_wrap done");
    endtask

    task automatic test_load_modes();
        write_a(4'b1000, 3'b010, 32'h11223344);
        write_a(4'b0001, 3'b100, 32'h89ABCDEF);
        write_a(4'b0010, 3'b101, 32'h89ABCDEF);
        write_a(4'b0100, 3'b111, 32'h89ABCDEF);
        write_a(4'b1000, 3'b110, 32'h89ABCDEF);
        a_sa = 2'd0; a_sb = 2'd1; #1;
        tests++;
        if (a_oa !== 32'h000000EF) begin
            fails++; $display("FAIL load_zext8: got %h want %h", a_oa, 32'h000000EF);
        end
        tests++;
        if (a_ob !== 32'h0000CDEF) begin
            fails++; $display("FAIL load_zext16: got %h want %h", a_ob, 32'h0000CDEF);
        end
        a_sa = 2'd2; a_sb = 2'd3; #1;
        tests++;
        if (a_oa !== 32'hFFFFCDEF) begin
            fails++; $display("FAIL load_sext_neg: got %h want %h", a_oa, 32'hFFFFCDEF);
        end
        tests++;
        if (a_ob !== 32'h223344EF) begin
            fails++; $display("FAIL load_shl8: got %h want %h", a_ob, 32'h223344EF);
        end
        write_a(4'b0100, 3'b111, 32'hFFFF5678);
        tests++;
        if (a_oa !== 32'h00005678) begin
            fails++; $display("FAIL load_sext_pos: got %h want %h", a_oa, 32'h00005678);
        end
        $display("[TB] test_load_modes done");
    endtask

    task automatic test_read_during_write();
        write_a(4'b0010, 3'b010, 32'h5);
        a_sa = 2'd1; a_sb = 2'd1;
        a_e = 4'b0010; a_fs = 3'b001; a_i = 32'h0;
        ma[1] = 6;
        #1;
        tests++;
        if (a_oa !== 32'h5 || a_ob !== 32'h5) begin
            fails++; $display("FAIL rdw_pre: got %h/%h want 5/5", a_oa, a_ob);
        end
        @(posedge clk); #1;
        a_e = '0;
        tests++;
        if (a_oa !== 32'h6 || a_ob !== 32'h6) begin
            fails++; $display("FAIL rdw_post: got %h/%h want 6/6", a_oa, a_ob);
        end
        write_a(4'b0000, 3'b001, 32'h0);
        tests++;
        if (a_oa !== 32'h6) begin
            fails++; $display("FAIL e_zero_noop: got %h want 6", a_oa);
        end
        $display("[TB] test_read_during_write done");
    endtask

    task automatic test_param();
        write_b(8'h01, 3'b111, 16'h8001);
        b_sa = 3'd0; #1;
        tests++;
        if (b_oa !== 16'h8001) begin
            fails++; $display("FAIL p16_sext: got %h want %h", b_oa, 16'h8001);
        end
        write_b(8'h02, 3'b010, 16'h1234);
        write_b(8'h02, 3'b110, 16'h00AB);
        b_sa = 3'd1; #1;
        tests++;
        if (b_oa !== 16'h34AB) begin
            fails++; $display("FAIL p16_shl8: got %h want %h", b_oa, 16'h34AB);
        end
        write_b(8'h80, 3'b010, 16'hFFFF);
        write_b(8'h80, 3'b001, 16'h0);
        b_sa = 3'd7; #1;
        tests++;
        if (b_oa !== 16'h0 || b_wrap !== 8'h80) begin
            fails++; $display("FAIL p16_wrap: got %h w=%b want 0 w=10000000", b_oa, b_wrap);
        end
        $display("[TB] test_param done");
    endtask

    task automatic test_random();
        logic [31:0] d32;
        logic [15:0] d16;
        logic [2:0]  fs;
        for (int n = 0; n < 150; n++) begin
            a_sa = 2'($urandom_range(0, 3)); a_sb = 2'($urandom_range(0, 3)); #1;
            tests++;
            if (a_oa !== ma[a_sa][31:0] || a_ob !== ma[a_sb][31:0] || a_wrap !== mwa) begin
                fails++;
                $display("FAIL rand32 #%0d: got %h/%h w=%b want %h/%h w=%b", n, a_oa, a_ob,
                         a_wrap, ma[a_sa][31:0], ma[a_sb][31:0], mwa);
            end
            fs = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: d32 = 32'hFFFFFFFF;
                1: d32 = 32'h0;
                default: d32 = $urandom;
            endcase
            write_a(4'($urandom), fs, d32);
        end
        for (int n = 0; n < 150; n++) begin
            b_sa = 3'($urandom_range(0, 7)); b_sb = 3'($urandom_range(0, 7)); #1;
            tests++;
            if (b_oa !== mb[b_sa][15:0] || b_ob !== mb[b_sb][15:0] || b_wrap !== mwb) begin
                fails++;
                $display("FAIL rand16 #%0d: got %h/%h w=%b want %h/%h w=%b", n, b_oa, b_ob,
                         b_wrap, mb[b_sa][15:0], mb[b_sb][15:0], mwb);
            end
            fs = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: d16 = 16'hFFFF;
                1: d16 = 16'h0;
                default: d16 = 16'($urandom);
            endcase
            write_b(8'($urandom), fs, d16);
        end
        $display("[TB] test_random done");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_e = '0; a_fs = '0; a_i = '0; a_sa = '0; a_sb = '0;
        b_e = '0; b_fs = '0; b_i = '0; b_sa = '0; b_sb = '0;
        clear_models();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #2;
        test_reset();
        test_multi_inc();
        test_wrap();
        test_load_modes();
        test_read_during_write();
        test_param();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
